// File: rtl/reg_piso_tx.sv
// reg_piso_tx: parallel-in/serial-out transmitter with valid/ready load and EN-gated shifting; optional even parity via PARITY_EN
module reg_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sdo_q, sdo_d;
    logic            done_q, done_d;
`ifdef PARITY_EN
    logic            par_q, par_d;
`endif

    // Next state: capture in IDLE, rotate the word so the next bit is always at the output end
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (load_valid) begin
                    state_d = SHIFT;
                    shreg_d = load_data;
                    count_d = '0;
                    sdo_d   = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
`ifdef PARITY_EN
                    par_d   = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (EN) begin
                    if (count_q == LAST) begin
`ifdef PARITY_EN
                        state_d = PAR;
                        sdo_d   = par_q;
`else
                        state_d = IDLE;
                        sdo_d   = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        shreg_d = LSB_FIRST ? {shreg_q[0], shreg_q[WIDTH-1:1]}
                                            : {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                        sdo_d   = LSB_FIRST ? shreg_q[1] : shreg_q[WIDTH-2];
                        count_d = count_q + 1'b1;
                    end
                end
            end
`ifdef PARITY_EN
            PAR: begin
                if (EN) begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
`endif
        endcase
    end

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign sdo_valid  = (state_q != IDLE);
    assign sdo        = sdo_q;
    assign done       = done_q;
endmodule

// File: tb/tb_reg_piso_tx.sv
// tb_reg_piso_tx: table vectors, directed corner sequences and random traffic against a queue-based frame model
module tb_reg_piso_tx;
    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic res, EN, load_valid;
    logic [W-1:0] load_data;
    logic o0_rdy, o0_sdo, o0_vld, o0_busy, o0_done;
    logic o1_rdy, o1_sdo, o1_vld, o1_busy, o1_done;

    int checks = 0;
    int errors = 0;
    bit q0[$];
    bit q1[$];
    bit md0 = 1'b0;
    bit md1 = 1'b0;

    always #5 clk = ~clk;

    reg_piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .res(res), .EN(EN), .load_valid(load_valid), .load_ready(o0_rdy),
        .load_data(load_data), .sdo(o0_sdo), .sdo_valid(o0_vld), .busy(o0_busy), .done(o0_done)
    );

    reg_piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .res(res), .EN(EN), .load_valid(load_valid), .load_ready(o1_rdy),
        .load_data(load_data), .sdo(o1_sdo), .sdo_valid(o1_vld), .busy(o1_busy), .done(o1_done)
    );

    function automatic void check(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0b expected %0b", nm, $time, act, exp);
        end
    endfunction

    // i-th transmitted bit of a frame carrying word d
    function automatic bit fbit(logic [W-1:0] d, bit lsb, int i);
        if (i >= W) return ^d;
        return lsb ? d[i] : d[W-1-i];
    endfunction

    // Model: a frame is a queue of pending bits; the head is on the line, each EN edge consumes one
    task automatic model_step();
        if (res) begin
            q0.delete();
            q1.delete();
            md0 = 1'b0;
            md1 = 1'b0;
        end else begin
            md0 = 1'b0;
            md1 = 1'b0;
            if (q0.size() == 0) begin
                if (load_valid) for (int i = 0; i < FL; i++) q0.push_back(fbit(load_data, 1'b0, i));
            end else if (EN) begin
                void'(q0.pop_front());
                md0 = (q0.size() == 0);
            end
            if (q1.size() == 0) begin
                if (load_valid) for (int i = 0; i < FL; i++) q1.push_back(fbit(load_data, 1'b1, i));
            end else if (EN) begin
                void'(q1.pop_front());
                md1 = (q1.size() == 0);
            end
        end
    endtask

    task automatic tick(input bit r, input bit en, input bit lv, input logic [W-1:0] d);
        res = r;
        EN = en;
        load_valid = lv;
        load_data = d;
        model_step();
        @(posedge clk);
        #1;
        check("msb.sdo", o0_sdo, q0.size() != 0 ? q0[0] : 1'b0);
        check("msb.sdo_valid", o0_vld, q0.size() != 0);
        check("msb.busy", o0_busy, q0.size() != 0);
        check("msb.load_ready", o0_rdy, q0.size() == 0);
        check("msb.done", o0_done, md0);
        check("lsb.sdo", o1_sdo, q1.size() != 0 ? q1[0] : 1'b0);
        check("lsb.sdo_valid", o1_vld, q1.size() != 0);
        check("lsb.busy", o1_busy, q1.size() != 0);
        check("lsb.load_ready", o1_rdy, q1.size() == 0);
        check("lsb.done", o1_done, md1);
    endtask

    typedef struct {
        bit         lv;
        logic [W-1:0] d;
        bit         sdo;
        bit         vld;
        bit         rdy;
        bit         dn;
    } vec_t;

    initial begin
        vec_t tv[10];
        logic [7:0] seq;
        seq = 8'b1010_0101;
        tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i < 8; i++) tv[i] = '{1'b0, 8'h00, seq[7-i], 1'b1, 1'b0, 1'b0};
`ifdef PARITY_EN
        tv[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        res = 1'b1; EN = 1'b0; load_valid = 1'b0; load_data = '0;
        tick(1, 0, 0, 8'h00);
        tick(1, 1, 1, 8'hFF);
        check("reset.ready", o0_rdy, 1'b1);
        check("reset.sdo", o0_sdo, 1'b0);
        // A5 MSB-first, EN high: fixed expectations from the table
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, tv[i].lv, tv[i].d);
            check($sformatf("tbl[%0d].sdo", i), o0_sdo, tv[i].sdo);
            check($sformatf("tbl[%0d].vld", i), o0_vld, tv[i].vld);
            check($sformatf("tbl[%0d].rdy", i), o0_rdy, tv[i].rdy);
            check($sformatf("tbl[%0d].done", i), o0_done, tv[i].dn);
        end
        // Stall after bit 2 for three cycles
        tick(0, 1, 1, 8'hA5);
        tick(0, 1, 0, 8'h00);
        tick(0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 8'h00);
            check("stall.hold", o0_sdo, 1'b1);
        end
        for (int i = 0; i < FL + 2; i++) tick(0, 1, 0, 8'h00);
        // Back-to-back: 01 then 80 presented continuously, accepted in the done cycle
        tick(0, 1, 1, 8'h01);
        for (int i = 0; i < 2 * FL + 3; i++) tick(0, 1, 1, 8'h80);
        for (int i = 0; i < FL + 2; i++) tick(0, 1, 0, 8'h00);
        // Reset mid-frame aborts without done
        tick(0, 1, 1, 8'hFF);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        check("abort.busy", o0_busy, 1'b0);
        check("abort.ready", o0_rdy, 1'b1);
        for (int i = 0; i < FL + 2; i++) begin
            tick(0, 1, 0, 8'h00);
            check("abort.nodone", o0_done, 1'b0);
        end
        // Parity-sensitive word 07, then 3C held during a frame
        tick(0, 1, 1, 8'h07);
        for (int i = 0; i < FL + 1; i++) tick(0, 1, 0, 8'h00);
        tick(0, 1, 1, 8'hC3);
        for (int i = 0; i < FL + 3; i++) tick(0, 1, 1, 8'h3C);
        for (int i = 0; i < FL + 2; i++) tick(0, 1, 0, 8'h00);
        // Random traffic
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, W'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
